// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counting timer with one-shot and auto-reload modes.
// Registers: CTRL, PRESET and COUNT, plus a level interrupt that can be masked.
module timer_counter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:2]  addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        intq
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic        enable;
   logic [1:0]  mode;
   logic        im;
   logic [31:0] preset;
   logic [31:0] count;
   logic        irq_pend;

   logic ctrl_wr, preset_wr;
   logic do_load, do_dec, set_pend, clr_pend, clr_en;

   assign ctrl_wr   = we && (addr == 2'd0);
   assign preset_wr = we && (addr == 2'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Enable going low takes priority over reaching zero, so a pause never raises an interrupt.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (enable) state_nxt = S_LOAD;
         S_LOAD: state_nxt = S_CNT;
         S_CNT: begin
            if (!enable)           state_nxt = S_IDLE;
            else if (count == '0)  state_nxt = S_INT;
         end
         S_INT: state_nxt = (mode == 2'd1) ? S_LOAD : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      do_load  = 1'b0;
      do_dec   = 1'b0;
      set_pend = 1'b0;
      clr_pend = 1'b0;
      clr_en   = 1'b0;
      case (state)
         S_LOAD: do_load = 1'b1;
         S_CNT: begin
            do_dec   = enable && (count != '0);
            set_pend = enable && (count == '0);
         end
         S_INT: begin
            clr_pend = (mode == 2'd1);
            clr_en   = (mode != 2'd1);
         end
         default: ;
      endcase
   end

   // A CPU write to CTRL overrides the one-shot auto-clear of Enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable   <= 1'b0;
         mode     <= 2'd0;
         im       <= 1'b0;
         preset   <= '0;
         count    <= '0;
         irq_pend <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            enable <= din[0];
            mode   <= din[2:1];
            im     <= din[3];
         end else if (clr_en) begin
            enable <= 1'b0;
         end

         if (preset_wr) preset <= din;

         if (do_load)     count <= preset;
         else if (do_dec) count <= count - 32'd1;

         if (ctrl_wr || preset_wr) irq_pend <= 1'b0;
         else if (set_pend)        irq_pend <= 1'b1;
         else if (clr_pend)        irq_pend <= 1'b0;
      end
   end

   always_comb begin
      case (addr)
         2'd0:    dout = {28'd0, im, mode, enable};
         2'd1:    dout = preset;
         2'd2:    dout = count;
         default: dout = '0;
      endcase
   end

   assign intq = im & irq_pend;

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped 32-bit down-counting timer that sits directly downstream of the CPU–peripheral bridge. It receives the word address bits, write strobe and write data the bridge routes to timer slot 0 (0x00007f00) or slot 1 (0x00007f10), and returns read data and a level interrupt request to the CPU's external interrupt vector. Two instances are built, one per slot. Each supports one-shot (mode 0) and auto-reload (mode 1) counting with a maskable interrupt.

## Interface

Parameters: none.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- addr  input  [3:2]  register select: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved
- we  input  1  write strobe, already qualified by the bridge for this slot
- din  input  32  write data from the CPU
- dout  output  32  read data, combinational on addr
- intq  output  1  interrupt request, level, active-high

## Operation

Registers:
- CTRL: bit 0 = Enable, bits 2:1 = Mode, bit 3 = IM (interrupt mask, 1 = allowed). Bits 31:4 are not stored and read as 0.
- PRESET: 32-bit reload value, read/write.
- COUNT: 32-bit current value, read-only. Writes to addr 2 are ignored.
- addr 3: reads 0; writes are ignored.
- Mode values 2 and 3 behave as mode 0.
- dout = CTRL, PRESET, COUNT or 0 according to addr.

State machine (2-bit state: IDLE, LOAD, CNT, INT):
- IDLE: if Enable = 1, go to LOAD; otherwise stay.
- LOAD: COUNT <= PRESET, then go to CNT.
- CNT:
  - Enable = 0: go to IDLE; COUNT holds.
  - COUNT = 0: go to INT and set irq_pend <= 1.
  - Otherwise: COUNT <= COUNT − 1.
- INT, mode 1: irq_pend <= 0, then go to LOAD.
- INT, mode 0: Enable <= 0, then go to IDLE; irq_pend stays set.

Interrupt:
- intq = IM & irq_pend.
- Any write to CTRL or PRESET clears irq_pend.

Boundary rules:
- PRESET = 0: the next edge after LOAD enters INT.
- PRESET = 0xFFFFFFFF: counts the full 32-bit range with no wrap. COUNT never decrements below 0.
- A PRESET write during counting does not change COUNT until the next LOAD.
- A CTRL write in the same cycle that INT clears Enable: the CPU write wins for all CTRL bits. irq_pend is still cleared by the write.
- A CTRL write with Enable = 0 while in CNT: the state reaches IDLE one edge later; COUNT is frozen and readable.
- Re-enabling from IDLE always reloads from PRESET; there is no resume.
- Reset asserted mid-count: the block returns to IDLE immediately and asynchronously.

## Timing

Reset values:
- CTRL = 0, PRESET = 0, COUNT = 0, irq_pend = 0, state = IDLE.
- Resulting outputs: intq = 0, dout = 0 for every addr.

Writes commit on the clk edge where we = 1. A read in the following cycle returns the new value.

Latency from the CTRL write edge E that sets Enable, with PRESET = N:
- edge E+1: state = LOAD
- edge E+2: COUNT = N, state = CNT
- edge E+2+N: COUNT = 0
- edge E+3+N: state = INT; intq rises if IM = 1

Mode 1:
- Interrupt period is exactly N+3 cycles.
- intq is high for exactly one cycle per period.

Mode 0:
- intq stays high until the next CTRL or PRESET write.
- Enable reads 0 from edge E+4+N onward.

## Test plan

- Reset: pulse rst_n low mid-count with N = 10 -> intq = 0 and CTRL, PRESET, COUNT read 0 immediately, with no clock edge needed.
- One-shot: PRESET = 5, then CTRL = 0x9 (Enable, mode 0, IM) -> COUNT reads 5,4,3,2,1,0; intq rises 8 cycles after the CTRL write and stays high; CTRL reads 0x8; writing CTRL = 0x8 drops intq on the next cycle.
- Auto-reload: PRESET = 3, CTRL = 0xB -> intq high for one cycle every 6 cycles across 4 periods; COUNT sequence 3,2,1,0 repeats.
- Masking and zero preset: PRESET = 0, CTRL = 0x1 -> irq_pend sets 3 cycles after the write, but intq stays 0; a later CTRL write of 0x9 re-enables and intq rises 3 cycles after it.
- Pause and PRESET update: mode 1, PRESET = 100; at COUNT = 40 write CTRL = 0x0 -> COUNT freezes at about 39. Then write PRESET = 7 and CTRL = 0xB -> counting restarts from 7.
- Register map: write 0xFFFFFFFF to addr 0, 2 and 3 -> addr 0 reads 0x0000000F, addr 2 is unchanged, addr 3 reads 0.
